// File: rtl/cpu_prog_sequencer_pkg.sv
// bali_seq_pkg: shared state encoding, opcode constant and sizing helper for the program sequencer
package bali_seq_pkg;
  typedef enum logic [2:0] {IDLE, CPU_RST, RUN, RECORD, DONE} seq_state_t;
  localparam logic [7:0] NOP = 8'h00;
  function automatic int sel_w(input int n);
    return n > 1 ? $clog2(n) : 1;
  endfunction
endpackage

// File: rtl/cpu_prog_sequencer_halt_detector.sv
// halt_detector: flags a run of HALT_CYCLES NOPs once the CPU has executed at least one real opcode
module halt_detector import bali_seq_pkg::*; #(
  parameter int HALT_CYCLES = 4,
  parameter logic [7:0] NOP_OP = NOP
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       clr,
  input  logic [7:0] op_code,
  output logic       halted
);
  localparam int CW = $clog2(HALT_CYCLES + 1);
  localparam logic [CW-1:0] LAST = CW'(HALT_CYCLES - 1);
  logic          armed;
  logic [CW-1:0] nop_run;
  logic          is_nop;
  assign is_nop = op_code == NOP_OP;
  // halt fires on the NOP that completes the run, so the sequencer can act on it the same edge
  assign halted = armed && is_nop && nop_run == LAST;
  // arm on the first real opcode, then count consecutive NOPs, saturating at the halt threshold
  always_ff @(posedge clk) begin
    if (!rst || clr) begin
      armed   <= 1'b0;
      nop_run <= '0;
    end else begin
      armed   <= armed | ~is_nop;
      nop_run <= !is_nop ? '0 : (armed && nop_run != LAST) ? nop_run + 1'b1 : nop_run;
    end
  end
endmodule

// File: rtl/cpu_prog_sequencer.sv
// cpu_prog_sequencer: runs each program slot on the CPU in turn and records halt-vs-timeout per slot
module cpu_prog_sequencer import bali_seq_pkg::*; #(
  parameter int PROG_COUNT  = 5,
  parameter int TIMEOUT     = 11000,
  parameter int RST_CYCLES  = 2,
  parameter int HALT_CYCLES = 4,
  parameter logic [7:0] NOP_OP = NOP,
  localparam int SW = sel_w(PROG_COUNT)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic [7:0]            op_code,
  output logic                  cpu_rst,
  output logic [SW-1:0]         prog_sel,
  output logic                  busy,
  output logic                  done,
  output logic                  result_valid,
  output logic [SW-1:0]         result_idx,
  output logic                  result_pass,
  output logic [PROG_COUNT-1:0] pass_mask,
  output logic [31:0]           cycle_count
);
  localparam int RW = $clog2(RST_CYCLES + 1);
  localparam logic [RW-1:0] RST_LAST = RW'(RST_CYCLES - 1);
  localparam logic [SW-1:0] LAST_SEL = SW'(PROG_COUNT - 1);
  seq_state_t  state;
  logic [RW-1:0] rst_cnt;
  logic        halted;
  logic [31:0] cc_next;
  logic        timeout;
  halt_detector #(.HALT_CYCLES(HALT_CYCLES), .NOP_OP(NOP_OP)) u_halt (
    .clk(clk),
    .rst(rst),
    .clr(state != RUN),
    .op_code(op_code),
    .halted(halted)
  );
  // run-cycle count saturates; timeout is judged on the count this cycle will reach
  always_comb begin
    cc_next = &cycle_count ? cycle_count : cycle_count + 32'd1;
    timeout = cc_next >= 32'(TIMEOUT);
  end
  // sequencer FSM with registered outputs; halt takes priority over a simultaneous timeout
  always_ff @(posedge clk) begin
    if (!rst) begin
      state        <= IDLE;
      cpu_rst      <= 1'b1;
      prog_sel     <= '0;
      busy         <= 1'b0;
      done         <= 1'b0;
      result_valid <= 1'b0;
      result_idx   <= '0;
      result_pass  <= 1'b0;
      pass_mask    <= '0;
      cycle_count  <= '0;
      rst_cnt      <= '0;
    end else begin
      result_valid <= 1'b0;
      case (state)
        IDLE, DONE: if (start) begin
          state       <= CPU_RST;
          busy        <= 1'b1;
          done        <= 1'b0;
          prog_sel    <= '0;
          pass_mask   <= '0;
          cycle_count <= '0;
          rst_cnt     <= '0;
        end
        CPU_RST: begin
          rst_cnt <= rst_cnt + 1'b1;
          if (rst_cnt == RST_LAST) begin
            state   <= RUN;
            cpu_rst <= 1'b0;
          end
        end
        RUN: begin
          cycle_count <= cc_next;
          if (halted || timeout) begin
            state               <= RECORD;
            cpu_rst             <= 1'b1;
            result_valid        <= 1'b1;
            result_idx          <= prog_sel;
            result_pass         <= halted;
            pass_mask[prog_sel] <= halted;
          end
        end
        RECORD: begin
          rst_cnt <= '0;
          if (prog_sel == LAST_SEL) begin
            state <= DONE;
            busy  <= 1'b0;
            done  <= 1'b1;
          end else begin
            state       <= CPU_RST;
            prog_sel    <= prog_sel + 1'b1;
            cycle_count <= '0;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_cpu_prog_sequencer.sv
// tb_cpu_prog_sequencer: stub-CPU scripts per slot, whole-sequence expected trace from a behavioural model
module tb_cpu_prog_sequencer;
  localparam int P  = 5;
  localparam int TO = 50;
  localparam int RC = 2;
  localparam int HC = 4;

  typedef struct {
    logic        cpu_rst;
    logic [2:0]  sel;
    logic        busy;
    logic        done;
    logic        rv;
    logic [2:0]  idx;
    logic        pass;
    logic [4:0]  mask;
    logic [31:0] cc;
  } exp_t;

  logic        clk, rst, start;
  logic [7:0]  op_code;
  logic        cpu_rst, busy, done, result_valid, result_pass;
  logic [2:0]  prog_sel, result_idx;
  logic [4:0]  pass_mask;
  logic [31:0] cycle_count;

  logic [7:0]  scr [P][64];
  logic [7:0]  junk;
  int          k;
  exp_t        exp_q [$];
  exp_t        steady;
  logic [2:0]  li;
  logic        lp;
  logic [31:0] rec_cc [P];
  logic        rec_pass [P];
  int          n_chk, n_fail;

  cpu_prog_sequencer #(.PROG_COUNT(P), .TIMEOUT(TO), .RST_CYCLES(RC), .HALT_CYCLES(HC), .NOP_OP(8'h00)) dut (
    .clk(clk), .rst(rst), .start(start), .op_code(op_code),
    .cpu_rst(cpu_rst), .prog_sel(prog_sel), .busy(busy), .done(done),
    .result_valid(result_valid), .result_idx(result_idx), .result_pass(result_pass),
    .pass_mask(pass_mask), .cycle_count(cycle_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // stub CPU: while out of reset it plays the script of the selected slot; in reset it emits junk
  always @(posedge clk) begin
    k    <= cpu_rst ? 0 : k + 1;
    junk <= 8'($urandom);
  end
  assign op_code = cpu_rst ? junk : scr[prog_sel][k > 63 ? 63 : k];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  function automatic exp_t mk(logic cr, logic [2:0] sel, logic b, logic d, logic v,
                              logic [2:0] idx, logic ps, logic [4:0] m, logic [31:0] cc);
    exp_t e;
    e.cpu_rst = cr; e.sel = sel; e.busy = b; e.done = d; e.rv = v;
    e.idx = idx; e.pass = ps; e.mask = m; e.cc = cc;
    return e;
  endfunction

  // a slot halts at the first run cycle t whose last HC opcodes are all NOP with some real opcode before them
  function automatic void slot_result(input int s, output bit p, output int c);
    bit win, seen;
    p = 1'b0;
    c = TO;
    for (int t = HC; t <= TO; t++) begin
      win  = 1'b1;
      seen = 1'b0;
      for (int i = t - HC; i < t; i++) if (scr[s][i] != 8'h00) win = 1'b0;
      for (int j = 0; j < t - HC; j++) if (scr[s][j] != 8'h00) seen = 1'b1;
      if (win && seen) begin
        p = 1'b1;
        c = t;
        return;
      end
    end
  endfunction

  task automatic build();
    bit p;
    int c;
    logic [4:0] m;
    m = '0;
    c = 0;
    for (int s = 0; s < P; s++) begin
      slot_result(s, p, c);
      for (int i = 0; i < RC; i++) exp_q.push_back(mk(1'b1, 3'(s), 1'b1, 1'b0, 1'b0, li, lp, m, 32'd0));
      for (int j = 1; j <= c; j++) exp_q.push_back(mk(1'b0, 3'(s), 1'b1, 1'b0, 1'b0, li, lp, m, 32'(j - 1)));
      m[s] = p;
      li = 3'(s);
      lp = p;
      exp_q.push_back(mk(1'b1, 3'(s), 1'b1, 1'b0, 1'b1, li, lp, m, 32'(c)));
    end
    steady = mk(1'b1, 3'(P - 1), 1'b0, 1'b1, 1'b0, li, lp, m, 32'(c));
  endtask

  // compare every cycle against the expected trace, or the settled state once the trace is consumed
  always @(negedge clk) begin : cmp
    exp_t e;
    if (exp_q.size() > 0) e = exp_q.pop_front();
    else e = steady;
    chk("cpu_rst", 32'(cpu_rst), 32'(e.cpu_rst));
    chk("prog_sel", 32'(prog_sel), 32'(e.sel));
    chk("busy", 32'(busy), 32'(e.busy));
    chk("done", 32'(done), 32'(e.done));
    chk("result_valid", 32'(result_valid), 32'(e.rv));
    chk("result_idx", 32'(result_idx), 32'(e.idx));
    chk("result_pass", 32'(result_pass), 32'(e.pass));
    chk("pass_mask", 32'(pass_mask), 32'(e.mask));
    chk("cycle_count", cycle_count, e.cc);
    if (result_valid === 1'b1 && result_idx < 3'(P)) begin
      rec_cc[result_idx]   = cycle_count;
      rec_pass[result_idx] = result_pass;
    end
  end

  task automatic fill(input int s, input logic [7:0] v);
    for (int i = 0; i < 64; i++) scr[s][i] = v;
  endtask

  task automatic put(input int s, input int from, input int n, input logic [7:0] v);
    for (int i = from; i < from + n; i++) scr[s][i] = v;
  endtask

  task automatic all_pass();
    for (int s = 0; s < P; s++) begin
      fill(s, 8'h00);
      put(s, 0, 10, 8'h10);
    end
  endtask

  task automatic model_lit(input string nm, input int s, input bit ep, input int ec);
    bit p;
    int c;
    slot_result(s, p, c);
    chk({nm, "_pass"}, 32'(p), 32'(ep));
    chk({nm, "_cycles"}, 32'(c), 32'(ec));
  endtask

  task automatic run_seq(input bit poke);
    @(posedge clk); #2 start = 1'b1;
    @(posedge clk); #2 start = 1'b0;
    build();
    for (int n = 0; n < 3000 && exp_q.size() > 0; n++) begin
      @(posedge clk); #2;
      start = (poke && n == 20) ? 1'b1 : 1'b0;
    end
    start = 1'b0;
    chk("drain", 32'(exp_q.size()), 32'd0);
    exp_q.delete();
    repeat (2) @(posedge clk);
    #2;
  endtask

  task automatic to_reset_model();
    exp_q.delete();
    li = '0;
    lp = 1'b0;
    steady = mk(1'b1, 3'd0, 1'b0, 1'b0, 1'b0, 3'd0, 1'b0, 5'd0, 32'd0);
  endtask

  initial begin
    rst = 1'b0;
    start = 1'b0;
    k = 0;
    junk = 8'h00;
    n_chk = 0;
    n_fail = 0;
    for (int s = 0; s < P; s++) fill(s, 8'h00);
    to_reset_model();
    repeat (3) @(posedge clk);
    #2;
    chk("reset_cpu_rst", 32'(cpu_rst), 32'd1);
    chk("reset_busy", 32'(busy), 32'd0);
    chk("reset_pass_mask", 32'(pass_mask), 32'd0);
    rst = 1'b1;

    all_pass();
    model_lit("model_allpass", 0, 1'b1, 14);
    run_seq(1'b0);
    chk("allpass_mask", 32'(pass_mask), 32'h1f);
    chk("allpass_done", 32'(done), 32'd1);

    all_pass();
    fill(2, 8'h10);
    model_lit("model_timeout", 2, 1'b0, 50);
    run_seq(1'b1);
    chk("timeout_mask", 32'(pass_mask), 32'h1b);
    chk("timeout_cc_s2", rec_cc[2], 32'd50);
    chk("timeout_pass_s2", 32'(rec_pass[2]), 32'd0);

    fill(0, 8'h00); put(0, 8, 3, 8'h10);
    fill(1, 8'h00); put(1, 3, 1, 8'h10);
    fill(2, 8'h00); put(2, 0, 47, 8'h10);
    fill(3, 8'h00); put(3, 0, 1, 8'h10); put(3, 4, 1, 8'h10);
    fill(4, 8'h00); put(4, 0, 46, 8'h10);
    model_lit("model_early", 0, 1'b1, 15);
    model_lit("model_glitch", 1, 1'b1, 8);
    model_lit("model_late", 2, 1'b0, 50);
    model_lit("model_rearm", 3, 1'b1, 9);
    model_lit("model_edge", 4, 1'b1, 50);
    run_seq(1'b1);
    chk("edge_mask", 32'(pass_mask), 32'h1b);
    chk("edge_cc_s4", rec_cc[4], 32'd50);
    chk("edge_pass_s4", 32'(rec_pass[4]), 32'd1);
    chk("early_cc_s0", rec_cc[0], 32'd15);

    all_pass();
    @(posedge clk); #2 start = 1'b1;
    @(posedge clk); #2 start = 1'b0;
    build();
    repeat (25) @(posedge clk);
    #2 rst = 1'b0;
    @(posedge clk); #2;
    to_reset_model();
    chk("midrst_cpu_rst", 32'(cpu_rst), 32'd1);
    chk("midrst_busy", 32'(busy), 32'd0);
    chk("midrst_valid", 32'(result_valid), 32'd0);
    chk("midrst_mask", 32'(pass_mask), 32'd0);
    chk("midrst_cc", cycle_count, 32'd0);
    @(posedge clk); #2 rst = 1'b1;
    repeat (3) @(posedge clk);
    #2;
    run_seq(1'b0);
    chk("after_rst_mask", 32'(pass_mask), 32'h1f);

    for (int r = 0; r < 8; r++) begin
      for (int s = 0; s < P; s++) begin
        int pn, tail;
        pn = int'($urandom_range(80, 20));
        tail = int'($urandom_range(63, 5));
        for (int i = 0; i < 64; i++)
          scr[s][i] = ($urandom_range(99) < pn) ? 8'h00 : 8'($urandom_range(255, 1));
        if ($urandom_range(1) == 1) put(s, tail, 64 - tail, 8'h00);
      end
      run_seq(r[0]);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
